cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
Upstream angle source for the cordic rotator. A phase accumulator is advanced by a programmable frequency control word (FCW) and folded to a first-quadrant angle index, which drives cordic z_tgt. The 2-bit quadrant of each sample is carried through a delay line matched to the cordic latency. The downstream unfold stage rotates cordic x_out/y_out by quadrant*90 degrees.

Parameters:
D_WIDTH, 11, cordic angle/data width; z_tgt carries D_WIDTH-1 angle bits.
ACC_WIDTH, 24, phase accumulator width; legal range is ACC_WIDTH >= D_WIDTH+1.
LATENCY, 12, cordic pipeline latency in cycles from z_tgt to x_out/y_out; legal range is LATENCY >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; begins generation
stop  in  1  single-cycle pulse; ends generation
fcw_wr  in  1  load strobe for the frequency control word
fcw_data  in  ACC_WIDTH  FCW, unsigned, modulo 2^ACC_WIDTH
z_tgt  out  D_WIDTH  angle index to cordic; MSB always 0
z_valid  out  1  z_tgt carries a valid sample
quad_out  out  2  quadrant of the sample now leaving the cordic
quad_valid  out  1  quad_out is valid
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset (at any time, including mid-RUN or mid-DRAIN):
  - state=IDLE.
  - acc=0, fcw=0, drain counter=0.
  - z_tgt=0, z_valid=0.
  - All delay-line stages cleared, so quad_out=0 and quad_valid=0.
  - Samples in flight at reset never produce quad_valid.
- FCW load: fcw_wr in any state loads fcw<=fcw_data at that edge. The first accumulation using the new value happens at the next edge.
- States:
  - IDLE: start -> RUN, and acc<=0 at the same edge. stop is ignored.
  - RUN: acc<=acc+fcw every cycle, modulo 2^ACC_WIDTH (wrap is silent). stop -> DRAIN. start is ignored. If start and stop occur together, stop wins.
  - DRAIN: acc holds. The counter counts LATENCY cycles, then the state returns to IDLE. start and stop are ignored.
- Angle folding, evaluated on the pre-edge acc:
  - q = acc[ACC_WIDTH-1:ACC_WIDTH-2].
  - f = acc[ACC_WIDTH-3 : ACC_WIDTH-2-(D_WIDTH-1)]; the lower bits are truncated with no rounding.
- Output registers, every edge:
  - z_tgt <= {1'b0, f}.
  - z_valid <= (state==RUN).
  - z_tgt updates in every state and is a don't-care when z_valid=0.
- Quadrant delay line:
  - LATENCY stages of {valid, q}, shifting every cycle regardless of state.
  - Stage 0 is loaded with {(state==RUN), q} at the same edge as z_tgt.
  - quad_out/quad_valid are the last stage. A sample registered at edge n appears at edge n+LATENCY.
- Latency rules:
  - start sampled at edge k: first z_valid=1 after edge k+1 with z_tgt=0.
  - Sample j (counting from 0) carries phase j*fcw.
- Stop timing:
  - stop sampled at edge m: the sample registered at edge m is the last valid one.
  - DRAIN is entered at edge m. IDLE and busy=0 follow at edge m+LATENCY, the same edge at which the last quad_valid=1 appears.
  - There is no quad_valid after that.
- Downstream contract, per quadrant (x,y = cordic outputs):
  - q=0: (x,y).
  - q=1: (-y,x).
  - q=2: (-x,-y).
  - q=3: (y,-x).
- Restart: a new start is only possible from IDLE. The accumulator restarts at phase 0, and the fcw register is preserved.

Test Plan:
1. Reset check: hold rst for 10 cycles mid-RUN -> z_tgt=0, z_valid=0, quad_out=0, quad_valid=0, busy=0, with no quad_valid for pre-reset samples.
2. Unit step: fcw=4096 (1 LSB of f at default widths), then start -> z_tgt = 0,1,...,1023 with q=0, then z_tgt=0 with q=1; each quad_out lags its z sample by exactly 12 cycles.
3. Quarter turn: fcw=2^22 -> z_tgt=0 on every sample; quad_out sequence 0,1,2,3,0,... starting 12 cycles after the first z_valid.
4. Negative step and wrap: fcw=2^24-4096 -> samples (z,q) = (0,0), (1023,3), (1022,3), ...; after 4096 samples the sequence returns to (0,0).
5. Stop and drain: stop at edge m -> z_valid=0 from edge m+1; busy=1 through edge m+11; the last quad_valid and busy=0 at edge m+12; a start pulsed during DRAIN has no effect.
6. FCW change mid-run: fcw 4096 -> 8192 via fcw_wr -> z_tgt increments switch from 1 to 2 starting one sample after the load edge, with no glitch on z_valid.

Source files
------------

// File: rtl/cordic_phase_gen.sv
// Phase accumulator that feeds the cordic rotator with a first-quadrant angle index.
// A {valid, quadrant} tag travels alongside the cordic pipeline so the unfold stage can restore the full circle.
module cordic_phase_gen #(
  parameter int D_WIDTH   = 11,
  parameter int ACC_WIDTH = 24,
  parameter int LATENCY   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 fcw_wr,
  input  logic [ACC_WIDTH-1:0] fcw_data,
  output logic [D_WIDTH-1:0]   z_tgt,
  output logic                 z_valid,
  output logic [1:0]           quad_out,
  output logic                 quad_valid,
  output logic                 busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic [ACC_WIDTH-1:0]   r_fcw;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [D_WIDTH-1:0]     r_z_tgt;
  logic                   r_z_valid;
  logic [LATENCY:0][2:0]  r_dly;

  logic                   w_run;
  logic [1:0]             w_q;
  logic [D_WIDTH-2:0]     w_f;

  assign w_run = (r_state == S_RUN);
  assign w_q   = r_acc[ACC_WIDTH-1 -: 2];
  // Quadrant bits dropped and the low bits truncated: the fold is a plain bit slice.
  assign w_f   = r_acc[ACC_WIDTH-3 -: D_WIDTH-1];

  always_comb begin
    w_next_state = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
          w_acc_next   = '0;
        end
      end
      S_RUN: begin
        w_acc_next = r_acc + r_fcw;
        if (stop) begin
          w_next_state = S_DRAIN;
          w_cnt_next   = '0;
        end
      end
      S_DRAIN: begin
        // Leaves DRAIN on the same edge the last tagged sample exits the delay line.
        if (r_cnt == CNT_W'(LATENCY - 1)) begin
          w_next_state = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcw <= '0;
    end else if (fcw_wr) begin
      r_fcw <= fcw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_tgt   <= '0;
      r_z_valid <= 1'b0;
    end else begin
      r_z_tgt   <= {1'b0, w_f};
      r_z_valid <= w_run;
    end
  end

  // Stage 0 lines up with z_tgt; stage LATENCY lines up with the cordic outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= {w_run, w_q};
      for (int i = 1; i <= LATENCY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign z_tgt      = r_z_tgt;
  assign z_valid    = r_z_valid;
  assign quad_valid = r_dly[LATENCY][2];
  assign quad_out   = r_dly[LATENCY][1:0];
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Bench for cordic_phase_gen: drivers push expected {edge, z} and {edge, quadrant} entries,
// a negedge monitor pops and compares them whenever z_valid or quad_valid is seen.
module tb_cordic_phase_gen;

  localparam int DW  = 11;
  localparam int AW  = 24;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          fcw_wr;
  logic [AW-1:0] fcw_data;
  logic [DW-1:0] z_tgt;
  logic          z_valid;
  logic [1:0]    quad_out;
  logic          quad_valid;
  logic          busy;

  cordic_phase_gen #(
    .D_WIDTH   (DW),
    .ACC_WIDTH (AW),
    .LATENCY   (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .fcw_wr     (fcw_wr),
    .fcw_data   (fcw_data),
    .z_tgt      (z_tgt),
    .z_valid    (z_valid),
    .quad_out   (quad_out),
    .quad_valid (quad_valid),
    .busy       (busy)
  );

  // ---------------- clock and edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [31+DW:0] exp_z_q[$];
  logic [33:0]    exp_qd_q[$];
  logic [33:0]    keep_q[$];
  logic [31+DW:0] mon_z;
  logic [33:0]    mon_qd;

  logic [AW-1:0] m_acc;
  logic [AW-1:0] m_fcw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Sample registered at edge e carries phase ph; its quadrant must leave LAT edges later.
  task automatic push_exp(input int e, input logic [AW-1:0] ph);
    exp_z_q.push_back({e[31:0], 1'b0, ph[AW-3 -: DW-1]});
    exp_qd_q.push_back({32'(e + LAT), ph[AW-1 -: 2]});
  endtask

  always @(negedge clk) begin
    if (z_valid === 1'b1) begin
      if (exp_z_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_z: got z_valid=1 z=0x%0h, expected no sample (cycle %0d)", z_tgt, cyc);
      end else begin
        mon_z = exp_z_q.pop_front();
        check("z_sample", {21'b0, cyc[31:0], z_tgt}, {21'b0, mon_z});
      end
    end
    if (quad_valid === 1'b1) begin
      if (exp_qd_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_quad: got quad_valid=1 q=%0d, expected none (cycle %0d)", quad_out, cyc);
      end else begin
        mon_qd = exp_qd_q.pop_front();
        check("quad_sample", {30'b0, cyc[31:0], quad_out}, {30'b0, mon_qd});
      end
    end
  end

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic load_fcw(input logic [AW-1:0] f);
    fcw_wr   = 1'b1;
    fcw_data = f;
    @(negedge clk);
    fcw_wr   = 1'b0;
    m_fcw    = f;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_acc = '0;
  endtask

  task automatic step(input bit do_wr, input logic [AW-1:0] wd);
    fcw_wr   = do_wr;
    fcw_data = wd;
    push_exp(cyc + 1, m_acc);
    m_acc = m_acc + m_fcw;
    if (do_wr) m_fcw = wd;
    @(negedge clk);
    fcw_wr = 1'b0;
  endtask

  task automatic stop_drain();
    stop = 1'b1;
    push_exp(cyc + 1, m_acc);
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_drain_m11", {63'b0, busy}, 64'd1);
    @(negedge clk);
    check("busy_idle_m12", {63'b0, busy}, 64'd0);
    repeat (4) @(negedge clk);
    check("z_queue_empty", 64'(exp_z_q.size()), 64'd0);
    check("quad_queue_empty", 64'(exp_qd_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_z_tgt"}, {53'b0, z_tgt}, 64'd0);
    check({tag, "_z_valid"}, {63'b0, z_valid}, 64'd0);
    check({tag, "_quad_out"}, {62'b0, quad_out}, 64'd0);
    check({tag, "_quad_valid"}, {63'b0, quad_valid}, 64'd0);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int r;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    fcw_wr   = 1'b0;
    fcw_data = '0;
    m_acc    = '0;
    m_fcw    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // Unit step: z counts 0..1023 in quadrant 0, then wraps into quadrant 1.
    load_fcw(24'd4096);
    start_run();
    repeat (1030) step(1'b0, '0);
    stop_drain();

    // Quarter turn: z stays 0 while the quadrant walks 0,1,2,3,0,...
    load_fcw(24'h400000);
    start_run();
    repeat (10) step(1'b0, '0);
    stop_drain();

    // Negative step: (0,0), (1023,3), (1022,3), ... back to (0,0) after 4096 samples.
    load_fcw(24'hFFF000);
    start_run();
    repeat (4100) step(1'b0, '0);
    stop_drain();

    // FCW change mid-run: step size goes from 1 to 2 one sample after the load edge.
    load_fcw(24'd4096);
    start_run();
    repeat (5) step(1'b0, '0);
    step(1'b1, 24'd8192);
    repeat (6) step(1'b0, '0);
    stop_drain();

    // Restart keeps the FCW (8192) and begins at phase 0.
    start_run();
    repeat (4) step(1'b0, '0);
    stop_drain();

    // Reset mid-RUN: samples whose quadrant has not yet emerged must never show quad_valid.
    load_fcw(24'd4096);
    start_run();
    repeat (20) step(1'b0, '0);
    rst = 1'b1;
    r = cyc + 1;
    keep_q = {};
    foreach (exp_qd_q[i]) begin
      if (int'(exp_qd_q[i][33:2]) < r) keep_q.push_back(exp_qd_q[i]);
    end
    exp_qd_q = keep_q;
    m_fcw = '0;
    repeat (10) @(negedge clk);
    check_reset_outputs("mid_run_rst");
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check_reset_outputs("post_rst");
    check("z_queue_empty_rst", 64'(exp_z_q.size()), 64'd0);
    check("quad_queue_empty_rst", 64'(exp_qd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
